// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Single-outstanding data-memory responder. A request is accepted in IDLE,
// held in capture registers while a LATENCY-cycle countdown runs in BUSY,
// and the memory access (load sample or store commit) happens on the
// BUSY->RESP edge. The registered response is held in RESP until the
// initiator accepts it.
//
// Optional feature macro: DMEM_WSTRB_EN
//   defined   : stores honour req_wstrb per byte (wstrb=0 changes nothing)
//   undefined : req_wstrb is ignored, every valid store writes all 64 bits
//
// Parameters
//   LATENCY  cycles from request acceptance to rsp_valid (1..15)
//   DEPTH    number of 64-bit memory words
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address (must be 8-byte aligned and < DEPTH*8)
//   req_wdata  in   store data
//   req_wstrb  in   store byte enables
//   rsp_valid  out  response present
//   rsp_ready  in   initiator accepts response
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  request was invalid, memory untouched
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic          r_rspValid;
    logic [63:0]   r_rspRdata;
    logic          r_rspErr;
    logic [63:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic [60:0]   w_wordAddr;
    logic          w_reqOk;
    logic [AW-1:0] w_idx;
    logic [63:0]   w_memWord;
    logic [63:0]   w_newWord;
    logic          w_we;

    // req_ready is forced low during reset so nothing is accepted while rst
    // is asserted, even though the state register already reads IDLE.
    assign req_ready  = (r_state == IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign w_commit   = (r_state == BUSY) && (r_cnt == 4'd0);

    // Validity is judged only on the captured address, never the live input.
    assign w_wordAddr = r_addr[63:3];
    assign w_reqOk    = (r_addr[2:0] == 3'b000) && (64'(w_wordAddr) < 64'(DEPTH));
    assign w_idx      = w_wordAddr[AW-1:0];
    assign w_memWord  = r_mem[w_idx];

`ifdef DMEM_WSTRB_EN
    logic [7:0]  r_wstrb;
    logic [63:0] w_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstrb <= 8'h00;
        end else if (w_accept) begin
            r_wstrb <= req_wstrb;
        end
    end

    // Expand byte enables into a bit mask and merge with the stored word.
    always_comb begin
        w_mask = 64'h0;
        for (int i = 0; i < 8; i++) begin
            w_mask[8*i +: 8] = {8{r_wstrb[i]}};
        end
    end

    assign w_newWord = (w_memWord & ~w_mask) | (r_wdata & w_mask);
    assign w_we      = w_commit && w_reqOk && r_write && (|r_wstrb);
`else
    logic w_unused;

    assign w_unused  = ^req_wstrb;
    assign w_newWord = r_wdata;
    assign w_we      = w_commit && w_reqOk && r_write;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = BUSY;
            BUSY:    if (w_commit)  w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Countdown loads LATENCY-1 so that RESP is entered exactly LATENCY
    // edges after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'(LATENCY - 1);
        end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture registers isolate the transaction from later input changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= 64'h0;
            r_wdata <= 64'h0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Memory contents are deliberately not reset. A reset during BUSY
    // drops r_state to IDLE asynchronously, so w_we cannot fire afterwards.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_newWord;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rspValid <= 1'b0;
            r_rspRdata <= 64'h0;
            r_rspErr   <= 1'b0;
        end else if (w_commit) begin
            r_rspValid <= 1'b1;
            r_rspErr   <= !w_reqOk;
            r_rspRdata <= (w_reqOk && !r_write) ? w_memWord : 64'h0;
        end else if ((r_state == RESP) && rsp_ready) begin
            r_rspValid <= 1'b0;
            r_rspRdata <= 64'h0;
            r_rspErr   <= 1'b0;
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Scoreboard bench for dmem_responder. The driver pushes the expected
// response when a request is accepted; an independent monitor pops and
// compares on every response handshake. The driver additionally checks
// latency, backpressure stability and reset behaviour.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    exp_t scoreboard[$];
    int   testsRun;
    int   testsFailed;

    dmem_responder #(
        .LATENCY(LAT),
        .DEPTH  (1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    // Monitor: a response is consumed on the edge after valid&&ready is seen.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (scoreboard.size() == 0) begin
                timeoutFail("unexpectedResponse");
            end else begin
                exp_t e;
                e = scoreboard.pop_front();
                checkOutput("rspRdata", rsp_rdata, e.rdata);
                checkOutput("rspErr", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // One complete transaction with `hold` extra cycles of backpressure.
    task automatic applyStimulus(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] wstrb, input logic [63:0] expRdata,
                                 input logic expErr, input int hold);
        bit          found;
        int          cyc;
        exp_t        e;
        logic [63:0] heldRdata;
        logic        heldErr;

        @(posedge clk); #2;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        req_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            timeoutFail("reqReady");
            req_valid = 1'b0;
            return;
        end
        e.rdata = expRdata;
        e.err   = expErr;
        scoreboard.push_back(e);
        @(posedge clk); #2;
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 64'h48;
        req_wdata = {$urandom, $urandom};
        req_wstrb = 8'h00;

        found = 0;
        cyc   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                found = 1;
                break;
            end
            checkOutput("reqReadyBusy", 64'(req_ready), 64'd0);
        end
        if (!found) begin
            timeoutFail("rspValid");
            return;
        end
        // First negedge after acceptance edge is cyc=1, so edges = cyc-1.
        checkOutput("latency", 64'(cyc - 1), 64'(LAT));

        heldRdata = rsp_rdata;
        heldErr   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            checkOutput("holdValid", 64'(rsp_valid), 64'd1);
            checkOutput("holdRdata", rsp_rdata, heldRdata);
            checkOutput("holdErr", 64'(rsp_err), 64'(heldErr));
            checkOutput("holdReqReady", 64'(req_ready), 64'd0);
        end

        @(posedge clk); #2;
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        rsp_ready = 1'b0;
        checkOutput("validAfterHs", 64'(rsp_valid), 64'd0);
        checkOutput("reqReadyAfterHs", 64'(req_ready), 64'd1);
    endtask

    // Store accepted, then reset pulsed one cycle later while still in BUSY.
    task automatic resetDuringBusy(input logic [63:0] addr, input logic [63:0] wdata);
        @(posedge clk); #2;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = 8'hFF;
        req_valid = 1'b1;
        @(negedge clk);
        checkOutput("rstReqReady", 64'(req_ready), 64'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("rstAsyncValid", 64'(rsp_valid), 64'd0);
        checkOutput("rstAsyncRdata", rsp_rdata, 64'h0);
        checkOutput("rstAsyncErr", 64'(rsp_err), 64'd0);
        checkOutput("rstAsyncReqReady", 64'(req_ready), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rstNoRsp", 64'(rsp_valid), 64'd0);
            checkOutput("rstIdleReady", 64'(req_ready), 64'd1);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 64'h0;
        req_wdata = 64'h0;
        req_wstrb = 8'h00;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("resetReqReady", 64'(req_ready), 64'd0);
        checkOutput("resetValid", 64'(rsp_valid), 64'd0);
        checkOutput("resetRdata", rsp_rdata, 64'h0);
        checkOutput("resetErr", 64'(rsp_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("releaseReqReady", 64'(req_ready), 64'd1);

        // Store then load
        applyStimulus(1'b1, 64'h40, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0, 0);
        applyStimulus(1'b0, 64'h40, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, 0);

        // Misaligned load, then the word is still intact
        applyStimulus(1'b0, 64'h44, 64'h0, 8'h00, 64'h0, 1'b1, 0);
        applyStimulus(1'b0, 64'h40, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, 0);

        // Out-of-range store leaves the boundary words alone
        applyStimulus(1'b1, 64'h0, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 64'h0, 1'b0, 0);
        applyStimulus(1'b1, 64'h1FF8, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 64'h0, 1'b0, 0);
        applyStimulus(1'b1, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1, 0);
        applyStimulus(1'b0, 64'h0, 64'h0, 8'h00, 64'hA5A5A5A5A5A5A5A5, 1'b0, 0);
        applyStimulus(1'b0, 64'h1FF8, 64'h0, 8'h00, 64'h5A5A5A5A5A5A5A5A, 1'b0, 0);

        // Backpressure for 5 cycles
        applyStimulus(1'b0, 64'h40, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, 5);

        // Reset in BUSY drops the pending store
        applyStimulus(1'b1, 64'h80, 64'h000000000000CAFE, 8'hFF, 64'h0, 1'b0, 0);
        resetDuringBusy(64'h80, 64'h000000000000DEAD);
        applyStimulus(1'b0, 64'h80, 64'h0, 8'h00, 64'h000000000000CAFE, 1'b0, 0);

        // Byte strobes
        applyStimulus(1'b1, 64'h0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b0, 0);
        applyStimulus(1'b1, 64'h0, 64'h0, 8'h0F, 64'h0, 1'b0, 0);
        applyStimulus(1'b1, 64'h8, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0, 0);
        applyStimulus(1'b1, 64'h8, 64'h0, 8'h00, 64'h0, 1'b0, 0);
`ifdef DMEM_WSTRB_EN
        applyStimulus(1'b0, 64'h0, 64'h0, 8'h00, 64'hFFFFFFFF00000000, 1'b0, 0);
        applyStimulus(1'b0, 64'h8, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0, 0);
`else
        applyStimulus(1'b0, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 0);
        applyStimulus(1'b0, 64'h8, 64'h0, 8'h00, 64'h0, 1'b0, 0);
`endif

        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboardEmpty", 64'(scoreboard.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
